// File: rtl/alu_operand_seq.sv
// Operand-fetch / writeback sequencer around a combinational 8-bit ALU.
// Holds a 4x8 register file plus carry flag; one instruction per 3 cycles.
module alu_operand_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [11:0] instr,
  input  logic        ld_en,
  input  logic [1:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  output logic [2:0]  alu_s,
  input  logic [7:0]  alu_data,
  input  logic        alu_cout,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        res_cout,
  output logic        carry,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 2;
  localparam int unsigned NREG = 4;
  localparam int unsigned SW   = 3;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [AW-1:0] rd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          cin_src;
    logic          cin_bit;
    logic          wb_en;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  instr_t        ins_c;
  logic          accept_c;
  logic          capture_c;
  logic          wb_c;
  logic          ld_c;
  logic [AW-1:0] rd_q;
  logic          wb_en_q;
  logic [DW-1:0] regs [NREG];

  assign ins_c = instr_t'(instr);

  // Next-state and per-state strobes
  always_comb begin
    state_n   = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    wb_c      = 1'b0;
    ld_c      = 1'b0;
    case (state)
      IDLE: begin
        ld_c = ld_en;
        if (instr_valid) begin
          accept_c = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_n   = WB;
      end
      WB: begin
        wb_c    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Handshake flags registered from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready <= 1'b1;
      res_valid   <= 1'b0;
    end else begin
      instr_ready <= (state_n == IDLE);
      res_valid   <= (state_n == WB);
    end
  end

  // Operand fetch; reads pre-load register values on a same-cycle preload
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      alu_s   <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
    end else if (accept_c) begin
      alu_a   <= regs[ins_c.ra];
      alu_b   <= regs[ins_c.rb];
      alu_cin <= ins_c.cin_src ? carry : ins_c.cin_bit;
      alu_s   <= ins_c.s;
      rd_q    <= ins_c.rd;
      wb_en_q <= ins_c.wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_cout <= 1'b0;
    end else if (capture_c) begin
      res_data <= alu_data;
      res_cout <= alu_cout;
    end
  end

  // Preload (IDLE only) and writeback (WB only) never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else begin
      if (ld_c)
        regs[ld_addr] <= ld_data;
      if (wb_c && wb_en_q)
        regs[rd_q] <= res_data;
    end
  end

  // Logic ops (select bit 2 set) leave the carry flag alone
  always_ff @(posedge clk) begin
    if (rst)
      carry <= 1'b0;
    else if (wb_c && !alu_s[SW-1])
      carry <= res_cout;
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a behavioural ALU model attached.
module tb_alu_operand_seq;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic        ld_en;
  logic [1:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [2:0]  alu_s;
  logic [7:0]  alu_data;
  logic        alu_cout;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_cout;
  logic        carry;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_cmp;
  int n_bad;

  alu_operand_seq dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
    .alu_data(alu_data), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout),
    .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU model: S=1xx is AND with Cout=0, otherwise A+B+Cin
  always_comb begin
    alu_data = '0;
    alu_cout = 1'b0;
    if (alu_s[2])
      alu_data = alu_a & alu_b;
    else
      {alu_cout, alu_data} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] enc(input logic [2:0] s, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb,
                                      input logic cs, input logic cb, input logic wb);
    return {s, rd, ra, rb, cs, cb, wb};
  endfunction

  task automatic check_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  // Issue one instruction and check its EXEC, capture and writeback cycles
  task automatic run(input string tag, input logic [11:0] ins,
                     input logic [7:0] ea, input logic [7:0] eb, input logic ecin,
                     input logic [7:0] ed, input logic ec, input logic exec_ld);
    check({tag, ".ready_in"}, 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    ld_en   = exec_ld;
    ld_addr = 2'd1;
    ld_data = 8'hAA;
    check({tag, ".ready_exec"}, 32'(instr_ready), 32'd0);
    check({tag, ".alu_a"}, 32'(alu_a), 32'(ea));
    check({tag, ".alu_b"}, 32'(alu_b), 32'(eb));
    check({tag, ".alu_cin"}, 32'(alu_cin), 32'(ecin));
    check({tag, ".rv_exec"}, 32'(res_valid), 32'd0);
    tick();
    ld_en = 1'b0;
    check({tag, ".rv_wb"}, 32'(res_valid), 32'd1);
    check({tag, ".res_data"}, 32'(res_data), 32'(ed));
    check({tag, ".res_cout"}, 32'(res_cout), 32'(ec));
    tick();
    check({tag, ".rv_done"}, 32'(res_valid), 32'd0);
    check({tag, ".ready_done"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst.ready", 32'(instr_ready), 32'd1);
    check("rst.res_valid", 32'(res_valid), 32'd0);
    check("rst.res_data", 32'(res_data), 32'd0);
    check("rst.res_cout", 32'(res_cout), 32'd0);
    check("rst.alu", 32'({alu_a, alu_b, alu_cin, alu_s}), 32'd0);
    check("rst.carry", 32'(carry), 32'd0);
    for (int i = 0; i < 4; i++) check_reg("rst.reg", 2'(i), 8'h00);
    tick();
    check("idle.ready", 32'(instr_ready), 32'd1);

    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h0F;
    tick();
    ld_addr = 2'd1; ld_data = 8'hF1;
    tick();
    ld_en = 1'b0;
    check_reg("pre.r0", 2'd0, 8'h0F);
    check_reg("pre.r1", 2'd1, 8'hF1);

    // 0x0F + 0xF1 = 0x100
    run("add1", enc(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1), 8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_reg("add1.r2", 2'd2, 8'h00);
    check("add1.carry", 32'(carry), 32'd1);

    // Back-to-back: carry-in from flag, R2 just written
    run("add2", enc(3'b000, 2'd3, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1), 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    check_reg("add2.r3", 2'd3, 8'h01);
    check("add2.carry", 32'(carry), 32'd0);

    // Set carry without writeback, then AND must not disturb it
    run("setc", enc(3'b000, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0), 8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("setc.carry", 32'(carry), 32'd1);
    run("and", enc(3'b100, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0), 8'h0F, 8'hF1, 1'b0, 8'h01, 1'b0, 1'b0);
    check("and.carry", 32'(carry), 32'd1);
    check_reg("and.r0", 2'd0, 8'h0F);
    check_reg("and.r1", 2'd1, 8'hF1);
    check_reg("and.r2", 2'd2, 8'h00);
    check_reg("and.r3", 2'd3, 8'h01);

    // Same-cycle preload + accept; preload during EXEC is dropped
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h55;
    run("ldacc", enc(3'b000, 2'd3, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1), 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b1);
    check_reg("ldacc.r0", 2'd0, 8'h55);
    check_reg("ldacc.r1", 2'd1, 8'hF1);
    check_reg("ldacc.r3", 2'd3, 8'h10);
    check("ldacc.carry", 32'(carry), 32'd0);

    // Reset during EXEC aborts the instruction
    instr = enc(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("abort.exec_ready", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.res_valid", 32'(res_valid), 32'd0);
    check("abort.ready", 32'(instr_ready), 32'd1);
    check("abort.res_data", 32'(res_data), 32'd0);
    check("abort.alu_a", 32'(alu_a), 32'd0);
    check("abort.carry", 32'(carry), 32'd0);
    for (int i = 0; i < 4; i++) check_reg("abort.reg", 2'(i), 8'h00);
    tick();
    check("abort.res_valid2", 32'(res_valid), 32'd0);
    check("abort.ready2", 32'(instr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
